sequence_az: RTL and testbench

//  Auto-zero measurement sequencer for the DMM input conditioning path.
//  - Drives the himux (U413), azmux (U414) and pre-charge switch through a fixed cycle: signal phase, then zero (LO) phase.
//  - Handshakes one ADC conversion per phase and raises meas_complete / spi_interrupt per cycle.
//  - Its outputs feed one input of the top-level mode mux (mux_4to1_assign) in place of reg_direct.
//

---
 rtl/sequence_az_pkg.sv | 32 +++
 rtl/sequence_az_counter_down.sv | 37 +++
 rtl/sequence_az.sv | 188 ++++++++++++++++++
 tb/tb_sequence_az.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_az_pkg.sv
// Shared types and constants for the auto-zero measurement sequencer.
// State encodings are fixed 4-bit codes because they are exported on the monitor bus.
package sequence_az_pkg;

    localparam int         CW_DEFAULT   = 24;
    localparam logic [3:0] MUX_OFF_CODE = 4'b0000;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SIG_SETTLE = 4'd1,
        ST_SIG_ACQ    = 4'd2,
        ST_LO_SETTLE  = 4'd3,
        ST_LO_ACQ     = 4'd4,
        ST_DONE       = 4'd5
    } state_t;

    // Mux codes captured at the start of every measurement cycle.
    typedef struct packed {
        logic [3:0] himux;
        logic [3:0] azmux_sig;
        logic [3:0] azmux_lo;
    } mux_cfg_t;

    function automatic logic is_acq(input state_t s);
        return (s == ST_SIG_ACQ) || (s == ST_LO_ACQ);
    endfunction

    function automatic logic is_settle(input state_t s);
        return (s == ST_SIG_SETTLE) || (s == ST_LO_SETTLE);
    endfunction

endpackage

// File: rtl/sequence_az_counter_down.sv
// Loadable down-counter shared by all timed sequencer states.
// A load of N leaves N-1 in the register (0 behaves as 1); it then counts to 0 and holds.
module sequence_az_counter_down #(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          zero
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (value == '0) ? '0 : (value - ONE);
        end else if (count_q != '0) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sequence_az.sv
// Auto-zero measurement sequencer: signal phase then LO phase, one ADC conversion each.
// Every output is a flop loaded from the decoded next state, so outputs track the state register.
module sequence_az
    import sequence_az_pkg::*;
#(
    parameter int         CW      = CW_DEFAULT,
    parameter logic [3:0] MUX_OFF = MUX_OFF_CODE
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [3:0]    p_himux_sel,
    input  logic [3:0]    p_azmux_sig,
    input  logic [3:0]    p_azmux_lo,
    input  logic [CW-1:0] p_clk_count_settle,
    input  logic [CW-1:0] p_clk_count_aperture,
    input  logic          adc_done,
    input  logic          int_clear,
    output logic          adc_start,
    output logic [3:0]    himux,
    output logic [3:0]    azmux,
    output logic          sw_pc_ctl,
    output logic          meas_complete,
    output logic          spi_interrupt,
    output logic [7:0]    meas_count,
    output logic          phase,
    output logic [7:0]    monitor
);

    state_t        state_q,        state_d;
    mux_cfg_t      cfg_q,          cfg_d;
    logic [CW-1:0] settle_q,       settle_d;
    logic [CW-1:0] aperture_q,     aperture_d;
    logic          done_latched_q, done_latched_d;

    logic          adc_start_q,     adc_start_d;
    logic [3:0]    himux_q,         himux_d;
    logic [3:0]    azmux_q,         azmux_d;
    logic          sw_pc_ctl_q,     sw_pc_ctl_d;
    logic          meas_complete_q, meas_complete_d;
    logic          spi_interrupt_q, spi_interrupt_d;
    logic [7:0]    meas_count_q,    meas_count_d;
    logic          phase_q,         phase_d;

    logic          snap;
    logic          entry;
    logic          done_seen;
    logic          cnt_load;
    logic [CW-1:0] cnt_value;
    logic          cnt_zero;

    sequence_az_counter_down #(
        .CW (CW)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .value   (cnt_value),
        .zero    (cnt_zero)
    );

    // A pulse on adc_done during the last aperture clock counts immediately.
    assign done_seen = done_latched_q | adc_done;
    assign snap      = enable && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:       state_d = ST_SIG_SETTLE;
                ST_SIG_SETTLE: if (cnt_zero)              state_d = ST_SIG_ACQ;
                ST_SIG_ACQ:    if (cnt_zero && done_seen) state_d = ST_LO_SETTLE;
                ST_LO_SETTLE:  if (cnt_zero)              state_d = ST_LO_ACQ;
                ST_LO_ACQ:     if (cnt_zero && done_seen) state_d = ST_DONE;
                ST_DONE:       state_d = ST_SIG_SETTLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // Parameters are frozen for the whole sig+lo cycle so mid-cycle writes wait a cycle.
    always_comb begin
        cfg_d      = cfg_q;
        settle_d   = settle_q;
        aperture_d = aperture_q;
        if (snap) begin
            cfg_d.himux     = p_himux_sel;
            cfg_d.azmux_sig = p_azmux_sig;
            cfg_d.azmux_lo  = p_azmux_lo;
            settle_d        = p_clk_count_settle;
            aperture_d      = p_clk_count_aperture;
        end
    end

    always_comb begin
        entry     = (state_d != state_q);
        cnt_load  = entry;
        cnt_value = is_acq(state_d) ? aperture_d : settle_d;
    end

    always_comb begin
        done_latched_d = 1'b0;
        if (is_acq(state_d) && !entry) begin
            done_latched_d = done_latched_q | adc_done;
        end
    end

    always_comb begin
        himux_d         = MUX_OFF;
        azmux_d         = MUX_OFF;
        sw_pc_ctl_d     = 1'b0;
        phase_d         = 1'b0;
        adc_start_d     = entry && is_acq(state_d);
        meas_complete_d = (state_d == ST_DONE);
        spi_interrupt_d = spi_interrupt_q & ~int_clear;
        meas_count_d    = meas_count_q;

        unique case (state_d)
            ST_SIG_SETTLE, ST_SIG_ACQ: begin
                himux_d     = cfg_d.himux;
                azmux_d     = cfg_d.azmux_sig;
                sw_pc_ctl_d = (state_d == ST_SIG_ACQ);
            end
            ST_LO_SETTLE, ST_LO_ACQ: begin
                himux_d     = cfg_d.himux;
                azmux_d     = cfg_d.azmux_lo;
                sw_pc_ctl_d = (state_d == ST_LO_ACQ);
                phase_d     = 1'b1;
            end
            ST_DONE: begin
                himux_d         = cfg_d.himux;
                azmux_d         = cfg_d.azmux_lo;
                phase_d         = 1'b1;
                spi_interrupt_d = 1'b1;
                meas_count_d    = meas_count_q + 8'd1;
            end
            default: begin
                himux_d = MUX_OFF;
                azmux_d = MUX_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cfg_q           <= '0;
            settle_q        <= '0;
            aperture_q      <= '0;
            done_latched_q  <= 1'b0;
            adc_start_q     <= 1'b0;
            himux_q         <= MUX_OFF;
            azmux_q         <= MUX_OFF;
            sw_pc_ctl_q     <= 1'b0;
            meas_complete_q <= 1'b0;
            spi_interrupt_q <= 1'b0;
            meas_count_q    <= 8'd0;
            phase_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cfg_q           <= cfg_d;
            settle_q        <= settle_d;
            aperture_q      <= aperture_d;
            done_latched_q  <= done_latched_d;
            adc_start_q     <= adc_start_d;
            himux_q         <= himux_d;
            azmux_q         <= azmux_d;
            sw_pc_ctl_q     <= sw_pc_ctl_d;
            meas_complete_q <= meas_complete_d;
            spi_interrupt_q <= spi_interrupt_d;
            meas_count_q    <= meas_count_d;
            phase_q         <= phase_d;
        end
    end

    assign adc_start     = adc_start_q;
    assign himux         = himux_q;
    assign azmux         = azmux_q;
    assign sw_pc_ctl     = sw_pc_ctl_q;
    assign meas_complete = meas_complete_q;
    assign spi_interrupt = spi_interrupt_q;
    assign meas_count    = meas_count_q;
    assign phase         = phase_q;
    assign monitor       = {state_q, adc_done, adc_start_q, phase_q, sw_pc_ctl_q};

endmodule

// File: tb/tb_sequence_az.sv
// Self-checking bench for sequence_az: timing table, randomized runs against a
// phase-duration model, and hand sequences for abort, interrupt, reset, wrap and param snapshot.
module tb_sequence_az;

    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [3:0]    p_himux_sel;
    logic [3:0]    p_azmux_sig;
    logic [3:0]    p_azmux_lo;
    logic [CW-1:0] p_clk_count_settle;
    logic [CW-1:0] p_clk_count_aperture;
    logic          adc_done = 1'b0;
    logic          int_clear;
    logic          adc_start;
    logic [3:0]    himux;
    logic [3:0]    azmux;
    logic          sw_pc_ctl;
    logic          meas_complete;
    logic          spi_interrupt;
    logic [7:0]    meas_count;
    logic          phase;
    logic [7:0]    monitor;

    sequence_az #(.CW(CW)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .enable               (enable),
        .p_himux_sel          (p_himux_sel),
        .p_azmux_sig          (p_azmux_sig),
        .p_azmux_lo           (p_azmux_lo),
        .p_clk_count_settle   (p_clk_count_settle),
        .p_clk_count_aperture (p_clk_count_aperture),
        .adc_done             (adc_done),
        .int_clear            (int_clear),
        .adc_start            (adc_start),
        .himux                (himux),
        .azmux                (azmux),
        .sw_pc_ctl            (sw_pc_ctl),
        .meas_complete        (meas_complete),
        .spi_interrupt        (spi_interrupt),
        .meas_count           (meas_count),
        .phase                (phase),
        .monitor              (monitor)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: one adc_done pulse k clocks after each adc_start (k=0 -> same clock), or tied high.
    bit done_tie = 1'b0;
    int k_sig = 0;
    int k_lo  = 0;
    int dly_cnt = -1;

    always @(negedge clk) begin
        if (!reset_n) begin
            dly_cnt  = -1;
            adc_done = 1'b0;
        end else if (done_tie) begin
            adc_done = 1'b1;
        end else begin
            adc_done = 1'b0;
            if (adc_start) dly_cnt = phase ? k_lo : k_sig;
            if (dly_cnt == 0) adc_done = 1'b1;
            if (dly_cnt >= 0) dly_cnt--;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timeout waiting for DUT", name);
    endtask

    // Expected clock offsets (relative to the clock where enable is first driven high):
    // each settle lasts max(s,1), each acquisition lasts max(max(a,1), k+1).
    function automatic void model(input int s, input int a, input int ks, input int kl,
                                  output int t_sig, output int t_lo, output int t_done);
        int settle_len;
        int ap_len;
        int sig_len;
        int lo_len;
        settle_len = (s < 1) ? 1 : s;
        ap_len     = (a < 1) ? 1 : a;
        sig_len    = (ap_len > ks) ? ap_len : ks + 1;
        lo_len     = (ap_len > kl) ? ap_len : kl + 1;
        t_sig  = 1 + settle_len;
        t_lo   = t_sig + sig_len + settle_len;
        t_done = t_lo + lo_len;
    endfunction

    task automatic set_params(input int s, input int a, input logic [3:0] hi,
                              input logic [3:0] sg, input logic [3:0] lo);
        p_clk_count_settle   = CW'(s);
        p_clk_count_aperture = CW'(a);
        p_himux_sel          = hi;
        p_azmux_sig          = sg;
        p_azmux_lo           = lo;
    endtask

    // One full measurement cycle, then enable drops during DONE.
    task automatic run_meas(input int s, input int a, input int ks, input int kl,
                            input logic [3:0] hi, input logic [3:0] sg, input logic [3:0] lo,
                            output int t_sig, output int t_lo, output int t_done);
        int base;
        @(negedge clk);
        set_params(s, a, hi, sg, lo);
        k_sig  = ks;
        k_lo   = kl;
        enable = 1'b1;
        base   = cyc;
        t_sig  = -1;
        t_lo   = -1;
        t_done = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (adc_start && !phase) begin
                t_sig = cyc - base;
                check("sig_mux {himux,azmux,sw}", {23'd0, himux, azmux, sw_pc_ctl}, {23'd0, hi, sg, 1'b1});
            end
            if (adc_start && phase) begin
                t_lo = cyc - base;
                check("lo_mux {himux,azmux,sw}", {23'd0, himux, azmux, sw_pc_ctl}, {23'd0, hi, lo, 1'b1});
            end
            if (meas_complete) begin
                t_done    = cyc - base;
                enable    = 1'b0;
                exp_count = (exp_count + 1) % 256;
                check("meas_count", meas_count, exp_count);
                check("spi_interrupt_set", spi_interrupt, 1);
                break;
            end
        end
        if (t_done < 0) timeout("run_meas");
    endtask

    task automatic wait_start(input logic ph, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (adc_start && (phase == ph)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout(name);
    endtask

    task automatic wait_complete(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (meas_complete) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout(name);
    endtask

    typedef struct {
        int s;
        int a;
        int ks;
        int kl;
        int e_sig;
        int e_lo;
        int e_done;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int t_sig, t_lo, t_done;
        int m_sig, m_lo, m_done;
        int n, last, base, mc_seen;
        logic [3:0] hi, sg, lo;

        // Hand-derived timing: nominal, early done, zero counts, late done, minimum counts.
        tbl[0] = '{s: 10, a: 100, ks: 105, kl: 105, e_sig: 11, e_lo: 127, e_done: 233};
        tbl[1] = '{s: 10, a: 100, ks: 0,   kl: 0,   e_sig: 11, e_lo: 121, e_done: 221};
        tbl[2] = '{s: 0,  a: 0,   ks: 0,   kl: 0,   e_sig: 2,  e_lo: 4,   e_done: 5};
        tbl[3] = '{s: 3,  a: 5,   ks: 7,   kl: 2,   e_sig: 4,  e_lo: 15,  e_done: 20};
        tbl[4] = '{s: 1,  a: 1,   ks: 3,   kl: 0,   e_sig: 2,  e_lo: 7,   e_done: 8};

        reset_n   = 1'b0;
        enable    = 1'b0;
        int_clear = 1'b0;
        set_params(0, 0, 4'h0, 4'h0, 4'h0);

        repeat (3) @(negedge clk);
        check("reset himux", himux, 0);
        check("reset azmux", azmux, 0);
        check("reset sw_pc_ctl", sw_pc_ctl, 0);
        check("reset adc_start", adc_start, 0);
        check("reset meas_complete", meas_complete, 0);
        check("reset spi_interrupt", spi_interrupt, 0);
        check("reset meas_count", meas_count, 0);
        check("reset phase", phase, 0);
        check("reset state", monitor[7:4], 0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_meas(tbl[i].s, tbl[i].a, tbl[i].ks, tbl[i].kl, 4'h9, 4'hA, 4'hB, t_sig, t_lo, t_done);
            check($sformatf("tbl%0d sig_start", i), t_sig, tbl[i].e_sig);
            check($sformatf("tbl%0d lo_start", i), t_lo, tbl[i].e_lo);
            check($sformatf("tbl%0d done", i), t_done, tbl[i].e_done);
            @(negedge clk);
            check($sformatf("tbl%0d idle_after", i), monitor[7:4], 0);
        end

        for (int i = 0; i < 25; i++) begin
            int s, a, ks, kl;
            s  = int'($urandom_range(0, 8));
            a  = int'($urandom_range(0, 8));
            ks = int'($urandom_range(0, 12));
            kl = int'($urandom_range(0, 12));
            hi = 4'($urandom_range(0, 15));
            sg = 4'($urandom_range(0, 15));
            lo = 4'($urandom_range(0, 15));
            model(s, a, ks, kl, m_sig, m_lo, m_done);
            run_meas(s, a, ks, kl, hi, sg, lo, t_sig, t_lo, t_done);
            check($sformatf("rnd%0d s=%0d a=%0d ks=%0d kl=%0d sig_start", i, s, a, ks, kl), t_sig, m_sig);
            check($sformatf("rnd%0d lo_start", i), t_lo, m_lo);
            check($sformatf("rnd%0d done", i), t_done, m_done);
        end

        // Mid-cycle p_azmux_lo change applies only to the following cycle.
        @(negedge clk);
        set_params(2, 3, 4'h5, 4'h6, 4'h3);
        k_sig  = 0;
        k_lo   = 0;
        enable = 1'b1;
        wait_start(1'b0, "param sig1");
        p_azmux_lo = 4'hC;
        wait_start(1'b1, "param lo1");
        check("param old azmux_lo", azmux, 4'h3);
        wait_complete("param done1");
        exp_count = (exp_count + 1) % 256;
        wait_start(1'b1, "param lo2");
        check("param new azmux_lo", azmux, 4'hC);
        wait_complete("param done2");
        exp_count = (exp_count + 1) % 256;
        enable = 1'b0;
        check("param meas_count", meas_count, exp_count);

        // Abort during SIG_ACQ.
        @(negedge clk);
        set_params(2, 50, 4'h7, 4'h1, 4'h2);
        k_sig  = 200;
        enable = 1'b1;
        wait_start(1'b0, "abort sig");
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort state idle", monitor[7:4], 0);
        check("abort himux safe", himux, 0);
        check("abort sw_pc_ctl", sw_pc_ctl, 0);
        mc_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (meas_complete) mc_seen++;
        end
        check("abort no meas_complete", mc_seen, 0);
        check("abort meas_count", meas_count, exp_count);
        k_sig = 0;

        // int_clear held high: clears, but DONE on the same clock still sets.
        @(negedge clk);
        int_clear = 1'b1;
        @(negedge clk);
        check("int_clear clears", spi_interrupt, 0);
        run_meas(0, 0, 0, 0, 4'h1, 4'h2, 4'h3, t_sig, t_lo, t_done);
        @(negedge clk);
        check("int_clear after done", spi_interrupt, 0);
        int_clear = 1'b0;

        // Zero counts with adc_done tied high: DONE every 5 clocks.
        @(negedge clk);
        set_params(0, 0, 4'h4, 4'h5, 4'h6);
        done_tie = 1'b1;
        enable   = 1'b1;
        base     = cyc;
        last     = base;
        n        = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (meas_complete) begin
                n++;
                exp_count = (exp_count + 1) % 256;
                check($sformatf("tie period %0d", n), cyc - last, 5);
                last = cyc;
            end
        end
        if (n < 4) timeout("tie cycles");
        enable   = 1'b0;
        done_tie = 1'b0;
        check("tie meas_count", meas_count, exp_count);

        // Asynchronous reset in the middle of LO_ACQ.
        @(negedge clk);
        set_params(3, 300, 4'hF, 4'hE, 4'hD);
        k_sig  = 0;
        k_lo   = 0;
        enable = 1'b1;
        wait_start(1'b1, "reset lo_acq");
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset himux", himux, 0);
        check("async reset azmux", azmux, 0);
        check("async reset sw_pc_ctl", sw_pc_ctl, 0);
        check("async reset meas_count", meas_count, 0);
        check("async reset state", monitor[7:4], 0);
        enable = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        exp_count = 0;

        // 256 cycles wrap the counter back to 0.
        @(negedge clk);
        set_params(0, 0, 4'h2, 4'h3, 4'h4);
        done_tie = 1'b1;
        enable   = 1'b1;
        n        = 0;
        for (int i = 0; i < 1500 && n < 256; i++) begin
            @(negedge clk);
            if (meas_complete) begin
                n++;
                exp_count = (exp_count + 1) % 256;
                if (n == 255) check("wrap count 255", meas_count, exp_count);
                if (n == 256) check("wrap count 0", meas_count, exp_count);
            end
        end
        if (n < 256) timeout("wrap");
        enable   = 1'b0;
        done_tie = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
